apb_master: RTL and testbench

//  APB3/APB4 requester: takes single transfer commands on a valid/ready port, runs APB SETUP/ACCESS

---
 rtl/apb_master_pkg.sv | 19 +
 rtl/apb_master_sel_decoder.sv | 20 ++
 rtl/apb_master.sv | 194 +++++++++++++++++++
 tb/tb_apb_master.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and width helpers for the APB requester.
// Latency: n/a (types only); backpressure: n/a.
package apb_master_pkg;

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_SETUP  = 2'd1,
        M_ACCESS = 2'd2
    } apb_mstate_e;

    function automatic int sel_bits(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int min1(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_master_sel_decoder.sv
// Maps the PSEL index field to a one-hot completer select; out-of-range indices select nothing.
// Latency: combinational; backpressure: none.
module apb_master_sel_decoder
    import apb_master_pkg::*;
#(
    parameter int NO_SLAVES = 4,
    parameter int IDX_W     = min1(sel_bits(NO_SLAVES))
) (
    input  logic [IDX_W-1:0]     idx_i,
    output logic [NO_SLAVES-1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NO_SLAVES; i++) begin
            if (idx_i == IDX_W'(i)) sel_o[i] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB3/4 requester: one command in, one SETUP/ACCESS transfer, one response pulse out.
// Latency: 3 cycles from idle, 2 back-to-back, plus wait states; backpressure: cmd_ready low until ACCESS completes, rsp never stalled.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NO_SLAVES      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [NO_SLAVES-1:0]    PSELx,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    output logic                    PENABLE,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR
);

    localparam int SEL_BITS = sel_bits(NO_SLAVES);
    localparam int IDX_W    = min1(SEL_BITS);
    localparam int WCW      = min1($clog2(TIMEOUT_CYCLES + 1));
    localparam int SW       = DATA_WIDTH / 8;
    localparam logic [WCW-1:0] WCNT_MAX  = '1;
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(TIMEOUT_CYCLES - 1);

    apb_mstate_e           state_q, state_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [NO_SLAVES-1:0]  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic [IDX_W-1:0]      sel_idx;
    logic [NO_SLAVES-1:0]  sel_dec;
    logic                  timeout_hit;
    logic                  accept;

    // A single completer needs no index bits; tie the index to zero so it always decodes.
    generate
        if (SEL_BITS == 0) begin : g_no_idx
            assign sel_idx = '0;
        end else begin : g_idx
            assign sel_idx = cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
        end
    endgenerate

    apb_master_sel_decoder #(
        .NO_SLAVES (NO_SLAVES),
        .IDX_W     (IDX_W)
    ) u_sel_decoder (
        .idx_i (sel_idx),
        .sel_o (sel_dec)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == M_ACCESS) && !PREADY
                         && (wait_cnt_q == WCNT_LAST);
    assign cmd_ready   = (state_q == M_IDLE) || ((state_q == M_ACCESS) && PREADY);
    assign accept      = cmd_valid && cmd_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            M_IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
            end
            M_SETUP: begin
                state_d    = M_ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            M_ACCESS: begin
                if (PREADY) begin
                    state_d       = M_IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = M_IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (wait_cnt_q != WCNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            default: begin
                state_d   = M_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase

        // Accept overrides the return to idle, giving the direct ACCESS->SETUP path.
        if (accept) begin
            state_d   = M_SETUP;
            paddr_d   = cmd_addr;
            pwrite_d  = cmd_write;
            pwdata_d  = cmd_wdata;
            pstrb_d   = cmd_write ? cmd_strb : '0;
            pprot_d   = cmd_prot;
            psel_d    = sel_dec;
            penable_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= M_IDLE;
            wait_cnt_q    <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSELx       = psel_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: inputs driven and outputs sampled on the falling edge.
// Latency: n/a; backpressure: n/a.
module tb_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [3:0]  PSELx;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PENABLE;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int vec_cnt = 0;
    int err_cnt = 0;

    apb_master #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .NO_SLAVES      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSELx       (PSELx),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PPROT       (PPROT),
        .PENABLE     (PENABLE),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
    endtask

    task automatic test_reset();
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        repeat (2) @(negedge PCLK);
        vec_cnt++; if (PSELx !== 4'b0000) begin err_cnt++; $display("FAIL rst_psel: got %b want 0000", PSELx); end
        vec_cnt++; if (PENABLE !== 1'b0) begin err_cnt++; $display("FAIL rst_penable: got %b want 0", PENABLE); end
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        vec_cnt++; if (PADDR !== 32'h0) begin err_cnt++; $display("FAIL rst_paddr: got %h want 0", PADDR); end
        PRESETn = 1'b1;
        @(negedge PCLK);
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write();
        drive_cmd(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        vec_cnt++; if (PSELx !== 4'b0001) begin err_cnt++; $display("FAIL wr_setup_psel: got %b want 0001", PSELx); end
        vec_cnt++; if (PENABLE !== 1'b0) begin err_cnt++; $display("FAIL wr_setup_penable: got %b want 0", PENABLE); end
        vec_cnt++; if (PWDATA !== 32'hDEAD_BEEF || PSTRB !== 4'hF || PWRITE !== 1'b1)
            begin err_cnt++; $display("FAIL wr_setup_fields: got %h/%h/%b want deadbeef/f/1", PWDATA, PSTRB, PWRITE); end
        vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL wr_setup_ready: got %b want 0", cmd_ready); end
        @(negedge PCLK);
        vec_cnt++; if (PENABLE !== 1'b1 || PSELx !== 4'b0001)
            begin err_cnt++; $display("FAIL wr_access: got en=%b sel=%b want 1/0001", PENABLE, PSELx); end
        PREADY = 1'b1;
        @(negedge PCLK);
        PREADY = 1'b0;
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
            begin err_cnt++; $display("FAIL wr_rsp: got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        vec_cnt++; if (PSELx !== 4'b0000 || PENABLE !== 1'b0)
            begin err_cnt++; $display("FAIL wr_idle_bus: got sel=%b en=%b want 0000/0", PSELx, PENABLE); end
        @(negedge PCLK);
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
        vec_cnt++; if (PADDR !== 32'h0000_0010) begin err_cnt++; $display("FAIL wr_paddr_hold: got %h want 00000010", PADDR); end
    endtask

    task automatic test_read_wait();
        drive_cmd(32'h4000_0004, 1'b0, 32'h0, 4'hF, 3'b010);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        vec_cnt++; if (PSELx !== 4'b0010) begin err_cnt++; $display("FAIL rd_setup_psel: got %b want 0010", PSELx); end
        vec_cnt++; if (PSTRB !== 4'h0 || PWRITE !== 1'b0 || PPROT !== 3'b010)
            begin err_cnt++; $display("FAIL rd_setup_fields: got strb=%h w=%b prot=%b want 0/0/010", PSTRB, PWRITE, PPROT); end
        @(negedge PCLK);
        for (int i = 0; i < 3; i++) begin
            vec_cnt++; if (PENABLE !== 1'b1 || PSELx !== 4'b0010 || PADDR !== 32'h4000_0004 || rsp_valid !== 1'b0)
                begin err_cnt++; $display("FAIL rd_wait_stable%0d: got en=%b sel=%b a=%h v=%b", i, PENABLE, PSELx, PADDR, rsp_valid); end
            @(negedge PCLK);
        end
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        @(negedge PCLK);
        PREADY = 1'b0;
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0)
            begin err_cnt++; $display("FAIL rd_rsp: got v=%b d=%h e=%b want 1/12345678/0", rsp_valid, rsp_rdata, rsp_err); end
        @(negedge PCLK);
    endtask

    task automatic test_slverr();
        drive_cmd(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'hCAFE_F00D;
        @(negedge PCLK);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D)
            begin err_cnt++; $display("FAIL slverr_rsp: got v=%b e=%b t=%b d=%h want 1/1/0/cafef00d", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        @(negedge PCLK);
        vec_cnt++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b1)
            begin err_cnt++; $display("FAIL slverr_hold: got v=%b e=%b want 0/1", rsp_valid, rsp_err); end
    endtask

    task automatic test_back_to_back();
        drive_cmd(32'h8000_0000, 1'b1, 32'h0000_0011, 4'h3, 3'b001);
        @(negedge PCLK);
        vec_cnt++; if (PSELx !== 4'b0100) begin err_cnt++; $display("FAIL b2b_first_psel: got %b want 0100", PSELx); end
        drive_cmd(32'hC000_0000, 1'b0, 32'h0, 4'hF, 3'b000);
        @(negedge PCLK);
        PREADY = 1'b1;
        PRDATA = 32'h55AA_55AA;
        #1;
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready_comb: got %b want 1", cmd_ready); end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0)
            begin err_cnt++; $display("FAIL b2b_first_rsp: got v=%b d=%h want 1/0", rsp_valid, rsp_rdata); end
        vec_cnt++; if (PSELx !== 4'b1000 || PENABLE !== 1'b0 || PADDR !== 32'hC000_0000)
            begin err_cnt++; $display("FAIL b2b_second_setup: got sel=%b en=%b a=%h want 1000/0/c0000000", PSELx, PENABLE, PADDR); end
        @(negedge PCLK);
        vec_cnt++; if (PENABLE !== 1'b1 || PSELx !== 4'b1000 || rsp_valid !== 1'b0)
            begin err_cnt++; $display("FAIL b2b_second_access: got en=%b sel=%b v=%b want 1/1000/0", PENABLE, PSELx, rsp_valid); end
        @(negedge PCLK);
        PREADY = 1'b0;
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55AA_55AA || PSELx !== 4'b0000)
            begin err_cnt++; $display("FAIL b2b_second_rsp: got v=%b d=%h sel=%b want 1/55aa55aa/0000", rsp_valid, rsp_rdata, PSELx); end
        @(negedge PCLK);
    endtask

    task automatic test_timeout();
        drive_cmd(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        for (int i = 0; i < 16; i++) begin
            vec_cnt++; if (PENABLE !== 1'b1 || rsp_valid !== 1'b0)
                begin err_cnt++; $display("FAIL to_wait%0d: got en=%b v=%b want 1/0", i, PENABLE, rsp_valid); end
            @(negedge PCLK);
        end
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
            begin err_cnt++; $display("FAIL to_rsp: got v=%b t=%b e=%b d=%h want 1/1/1/0", rsp_valid, rsp_timeout, rsp_err, rsp_rdata); end
        vec_cnt++; if (PSELx !== 4'b0000 || PENABLE !== 1'b0)
            begin err_cnt++; $display("FAIL to_bus: got sel=%b en=%b want 0000/0", PSELx, PENABLE); end
        @(negedge PCLK);
    endtask

    task automatic test_timeout_race();
        drive_cmd(32'h4000_0100, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (16) @(negedge PCLK);
        PREADY = 1'b1;
        PRDATA = 32'h0BAD_F00D;
        @(negedge PCLK);
        PREADY = 1'b0;
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D)
            begin err_cnt++; $display("FAIL race_rsp: got v=%b t=%b e=%b d=%h want 1/0/0/0badf00d", rsp_valid, rsp_timeout, rsp_err, rsp_rdata); end
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid();
        drive_cmd(32'h8000_0008, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        vec_cnt++; if (PSELx !== 4'b0000 || PENABLE !== 1'b0 || rsp_valid !== 1'b0)
            begin err_cnt++; $display("FAIL rstmid_async: got sel=%b en=%b v=%b want 0000/0/0", PSELx, PENABLE, rsp_valid); end
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_no_rsp: got %b want 0", rsp_valid); end
        drive_cmd(32'h4000_0008, 1'b1, 32'hA5A5_0001, 4'h1, 3'b100);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        vec_cnt++; if (PSELx !== 4'b0010 || PSTRB !== 4'h1)
            begin err_cnt++; $display("FAIL rstmid_next_setup: got sel=%b strb=%h want 0010/1", PSELx, PSTRB); end
        @(negedge PCLK);
        PREADY = 1'b1;
        @(negedge PCLK);
        PREADY = 1'b0;
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
            begin err_cnt++; $display("FAIL rstmid_next_rsp: got v=%b e=%b t=%b want 1/0/0", rsp_valid, rsp_err, rsp_timeout); end
        @(negedge PCLK);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
